// File: rtl/reset_sequencer_pf.sv
// reset_sequencer_pf: staged per-channel fabric reset release gated by PLL lock and device init
module reset_sequencer_pf #(
    parameter int NUM_CH     = 4,
    parameter int STAGE_DLY  = 16,
    parameter int LOCK_FILT  = 8,
    parameter int MIN_ASSERT = 32
) (
    input  logic              CLK,
    input  logic              EXT_RST_N,
    input  logic              PLL_LOCK,
    input  logic              INIT_DONE,
    input  logic              SW_RST_REQ,
    input  logic              FF_US_RESTORE,
    output logic [NUM_CH-1:0] FABRIC_RESET_N,
    output logic              ALL_RELEASED,
    output logic [1:0]        STATE,
    output logic [7:0]        LOCK_LOSS_CNT
);
    localparam int HW  = (MIN_ASSERT > 1) ? $clog2(MIN_ASSERT) : 1;
    localparam int FW  = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int STW = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [HW-1:0]  HOLD_LAST  = HW'(MIN_ASSERT - 1);
    localparam logic [FW-1:0]  FILT_LAST  = FW'(LOCK_FILT - 1);
    localparam logic [STW-1:0] STAGE_LAST = STW'(STAGE_DLY - 1);
    localparam logic [CW-1:0]  CH_LAST    = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [1:0]        rst_sync;
    logic [1:0]        pll_sync;
    logic [1:0]        init_sync;
    logic              INTERNAL_RST_N;
    logic              qual;
    logic              loss;
    state_t            state, state_nxt;
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic [FW-1:0]     filt_cnt, filt_nxt;
    logic [STW-1:0]    stage_cnt, stage_nxt;
    logic [CW-1:0]     ch_idx, ch_nxt;
    logic [NUM_CH-1:0] fab_q, fab_nxt;
    logic [7:0]        loss_cnt, loss_nxt;

    assign INTERNAL_RST_N = rst_sync[1];
    assign qual           = pll_sync[1] & init_sync[1];
    assign loss           = ~qual & (state == RELEASE || state == RUN);
    assign FABRIC_RESET_N = fab_q | {NUM_CH{FF_US_RESTORE}};
    assign ALL_RELEASED   = (state == RUN);
    assign STATE          = state;
    assign LOCK_LOSS_CNT  = loss_cnt;

    // Reset asserts at once and releases two clocks later; lock/init inputs are double-flopped
    always_ff @(posedge CLK or negedge EXT_RST_N) begin
        if (!EXT_RST_N) begin
            rst_sync  <= '0;
            pll_sync  <= '0;
            init_sync <= '0;
        end else begin
            rst_sync  <= {rst_sync[0], 1'b1};
            pll_sync  <= {pll_sync[0], PLL_LOCK};
            init_sync <= {init_sync[0], INIT_DONE};
        end
    end

    // Sequencer state, counters and registered channel resets
    always_ff @(posedge CLK or negedge INTERNAL_RST_N) begin
        if (!INTERNAL_RST_N) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            filt_cnt  <= '0;
            stage_cnt <= '0;
            ch_idx    <= '0;
            fab_q     <= '0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            filt_cnt  <= filt_nxt;
            stage_cnt <= stage_nxt;
            ch_idx    <= ch_nxt;
            fab_q     <= fab_nxt;
            loss_cnt  <= loss_nxt;
        end
    end

    // Next state: freeze beats abort (request or qualifier loss) beats normal progression
    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        filt_nxt  = '0;
        stage_nxt = '0;
        ch_nxt    = ch_idx;
        fab_nxt   = fab_q;
        loss_nxt  = loss_cnt;
        if (FF_US_RESTORE) begin
            hold_nxt  = hold_cnt;
            filt_nxt  = filt_cnt;
            stage_nxt = stage_cnt;
        end else if (state != HOLD && (SW_RST_REQ || loss)) begin
            state_nxt = HOLD;
            ch_nxt    = '0;
            fab_nxt   = '0;
            loss_nxt  = (loss && loss_cnt != 8'hff) ? loss_cnt + 8'd1 : loss_cnt;
        end else begin
            case (state)
                HOLD: begin
                    if (!SW_RST_REQ) begin
                        if (hold_cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
                        else hold_nxt = hold_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (qual) begin
                        if (filt_cnt == FILT_LAST) state_nxt = RELEASE;
                        else filt_nxt = filt_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (stage_cnt == STAGE_LAST) begin
                        fab_nxt = fab_q | (NUM_CH'(1) << ch_idx);
                        if (ch_idx == CH_LAST) begin
                            state_nxt = RUN;
                            ch_nxt    = '0;
                        end else begin
                            ch_nxt = ch_idx + 1'b1;
                        end
                    end else begin
                        stage_nxt = stage_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reset_sequencer_pf.sv
// tb_reset_sequencer_pf: directed and random stimulus against a cycle-level behavioural model
module tb_reset_sequencer_pf;
    localparam int MIN_A = 32;
    localparam int FILT  = 8;

    logic       CLK = 1'b0;
    logic       EXT_RST_N = 1'b0;
    logic       PLL_LOCK = 1'b0;
    logic       INIT_DONE = 1'b0;
    logic       SW_RST_REQ = 1'b0;
    logic       FF_US_RESTORE = 1'b0;
    logic [3:0] fab0;
    logic [0:0] fab1;
    logic       ar0, ar1;
    logic [1:0] st0, st1;
    logic [7:0] llc0, llc1;
    int         total = 0;
    int         bad = 0;
    int         cn = 0;

    // ph: phase 0..3, e: clocks spent in the phase (or since the last request in phase 0)
    typedef struct packed {
        logic [1:0] ph;
        int         e;
        int         lc;
        logic       r0, r1, p0, p1, i0, i1;
    } mdl_t;
    mdl_t m0, m1;

    always #5 CLK = ~CLK;

    reset_sequencer_pf u_dut0 (
        .CLK(CLK), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
        .SW_RST_REQ(SW_RST_REQ), .FF_US_RESTORE(FF_US_RESTORE), .FABRIC_RESET_N(fab0),
        .ALL_RELEASED(ar0), .STATE(st0), .LOCK_LOSS_CNT(llc0)
    );

    reset_sequencer_pf #(.NUM_CH(1), .STAGE_DLY(1)) u_dut1 (
        .CLK(CLK), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
        .SW_RST_REQ(SW_RST_REQ), .FF_US_RESTORE(FF_US_RESTORE), .FABRIC_RESET_N(fab1),
        .ALL_RELEASED(ar1), .STATE(st1), .LOCK_LOSS_CNT(llc1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t step(input mdl_t m, input int nch, input int sd);
        mdl_t n;
        logic q, lost;
        n    = m;
        q    = m.p1 & m.i1;
        lost = !q && m.ph >= 2'd2;
        n.r0 = 1'b1;
        n.r1 = m.r0;
        n.p0 = PLL_LOCK;
        n.p1 = m.p0;
        n.i0 = INIT_DONE;
        n.i1 = m.i0;
        if (!EXT_RST_N) begin
            n = '0;
        end else if (!m.r1) begin
            n.ph = 2'd0;
            n.e  = 0;
            n.lc = 0;
        end else if (!FF_US_RESTORE) begin
            if (m.ph != 2'd0 && (SW_RST_REQ || lost)) begin
                n.ph = 2'd0;
                n.e  = 0;
                if (lost && m.lc < 255) n.lc = m.lc + 1;
            end else begin
                case (m.ph)
                    2'd0: begin
                        n.e = SW_RST_REQ ? 0 : m.e + 1;
                        if (n.e == MIN_A) begin n.ph = 2'd1; n.e = 0; end
                    end
                    2'd1: begin
                        n.e = q ? m.e + 1 : 0;
                        if (n.e == FILT) begin n.ph = 2'd2; n.e = 0; end
                    end
                    2'd2: begin
                        n.e = m.e + 1;
                        if (n.e / sd >= nch) begin n.ph = 2'd3; n.e = 0; end
                    end
                    default: ;
                endcase
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] efab(input mdl_t m, input int nch, input int sd);
        logic [15:0] all;
        all = 16'((32'd1 << nch) - 1);
        if (FF_US_RESTORE || m.ph == 2'd3) return all;
        if (m.ph == 2'd2) return 16'((32'd1 << (m.e / sd)) - 1);
        return 16'd0;
    endfunction

    task automatic cyc();
        if (!EXT_RST_N) begin m0 = '0; m1 = '0; end
        @(posedge CLK);
        m0 = step(m0, 4, 16);
        m1 = step(m1, 1, 1);
        @(negedge CLK);
        cn++;
        chk("state0", 32'(st0), 32'(m0.ph));
        chk("allrel0", 32'(ar0), 32'(m0.ph == 2'd3));
        chk("fabric0", 32'(fab0), 32'(efab(m0, 4, 16)));
        chk("losscnt0", 32'(llc0), m0.lc);
        chk("state1", 32'(st1), 32'(m1.ph));
        chk("allrel1", 32'(ar1), 32'(m1.ph == 2'd3));
        chk("fabric1", 32'(fab1), 32'(efab(m1, 1, 1)));
        chk("losscnt1", 32'(llc1), m1.lc);
    endtask

    task automatic do_reset();
        EXT_RST_N     = 1'b0;
        PLL_LOCK      = 1'b1;
        INIT_DONE     = 1'b1;
        SW_RST_REQ    = 1'b0;
        FF_US_RESTORE = 1'b0;
        repeat (3) cyc();
        EXT_RST_N = 1'b1;
        cn = -2;
    endtask

    initial begin
        int first [8];
        int j;
        int unsigned dens [4];
        m0 = '0;
        m1 = '0;
        dens = '{0, 600, 150, 20};

        do_reset();
        for (int k = 0; k < 8; k++) first[k] = -1;
        repeat (112) begin
            cyc();
            if (first[0] < 0 && st0 == 2'd1) first[0] = cn;
            if (first[1] < 0 && st0 == 2'd2) first[1] = cn;
            for (int k = 0; k < 4; k++) if (first[2+k] < 0 && fab0[k]) first[2+k] = cn;
            if (first[6] < 0 && ar0) first[6] = cn;
            if (first[7] < 0 && st1 == 2'd3) first[7] = cn;
        end
        chk("t_wait_lock", first[0], 32);
        chk("t_release", first[1], 40);
        chk("t_ch0", first[2], 56);
        chk("t_ch1", first[3], 72);
        chk("t_ch2", first[4], 88);
        chk("t_ch3", first[5], 104);
        chk("t_allrel", first[6], 104);
        chk("t_run_1ch", first[7], 41);

        PLL_LOCK = 1'b0;
        repeat (3) cyc();
        chk("loss_state", 32'(st0), 0);
        chk("loss_fabric", 32'(fab0), 0);
        chk("loss_cnt", 32'(llc0), 1);
        PLL_LOCK = 1'b1;
        repeat (106) cyc();
        chk("relock_run", 32'(st0), 3);

        do_reset();
        j = 0;
        while (!(m0.ph == 2'd1 && m0.e == 5) && j < 100) begin cyc(); j++; end
        PLL_LOCK = 1'b0;
        cyc();
        PLL_LOCK = 1'b1;
        j = 0;
        while (st0 != 2'd2 && j < 100) begin cyc(); j++; end
        chk("filt_restart", cn, 48);
        chk("filt_losscnt", 32'(llc0), 0);

        do_reset();
        j = 0;
        while (!(m0.ph == 2'd2 && m0.e == 32) && j < 200) begin cyc(); j++; end
        SW_RST_REQ = 1'b1;
        cyc();
        SW_RST_REQ = 1'b0;
        chk("sw_state", 32'(st0), 0);
        chk("sw_fabric", 32'(fab0), 0);
        chk("sw_losscnt", 32'(llc0), 0);
        j = 0;
        while (st0 != 2'd1 && j < 100) begin cyc(); j++; end
        chk("sw_hold_len", j, 32);

        do_reset();
        j = 0;
        while (m0.ph != 2'd2 && j < 100) begin cyc(); j++; end
        FF_US_RESTORE = 1'b1;
        repeat (20) begin
            cyc();
            chk("ff_fabric", 32'(fab0), 32'hf);
        end
        chk("ff_state", 32'(st0), 2);
        FF_US_RESTORE = 1'b0;
        j = 0;
        do begin cyc(); j++; end while (!fab0[0] && j < 40);
        chk("ff_ch0_delay", j, 16);

        for (int s = 0; s < 30; s++) begin
            int unsigned den;
            int len, rl, fl;
            den = dens[$urandom_range(0, 3)];
            len = $urandom_range(150, 400);
            rl  = 0;
            fl  = 0;
            for (int c = 0; c < len; c++) begin
                if (rl > 0) rl--;
                else if ($urandom_range(0, 999) == 0) rl = $urandom_range(1, 3);
                if (fl > 0) fl--;
                else if ($urandom_range(0, 299) == 0) fl = $urandom_range(1, 25);
                EXT_RST_N     = (rl == 0);
                FF_US_RESTORE = (fl > 0);
                PLL_LOCK      = (den == 0) || ($urandom_range(1, den) != 1);
                INIT_DONE     = $urandom_range(0, 999) != 0;
                SW_RST_REQ    = $urandom_range(0, 399) == 0;
                cyc();
            end
        end

        do_reset();
        for (int k = 0; k < 300; k++) begin
            j = 0;
            do begin cyc(); j++; end while (st1 != 2'd3 && j < 200);
            if (st1 != 2'd3) chk("sat_reach_run", 32'(st1), 3);
            PLL_LOCK = 1'b0;
            repeat (3) cyc();
            PLL_LOCK = 1'b1;
        end
        chk("sat_losscnt", 32'(llc1), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
